// File: rtl/md_unit_if.sv
// Port bundle of the multiply/divide unit: E-stage request side plus status and HI/LO outputs.
// start is taken on an edge where busy is low; a start seen while busy is high is dropped.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             dbg_state;

    modport master (
        output start, op, a, b,
        input  busy, done, hi_out, lo_out, dbg_state
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi_out, lo_out, dbg_state
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO: the result is computed at accept and held
// in a shadow register until the busy window expires, then committed to HI/LO.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  md
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]        hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]        res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic                    wr_q, wr_d, done_q, done_d;

    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic                      div_ovf, div_zero;
    logic [WIDTH-1:0]          div_b;
    logic signed [WIDTH-1:0]   q_s_raw, r_s_raw;
    logic [WIDTH-1:0]          q_s, r_s, q_u, r_u;

    // Zero and MIN/-1 divisors are replaced by 1 so the divider never sees an undefined case.
    always_comb begin
        prod_s   = $signed({{WIDTH{md.a[WIDTH-1]}}, md.a}) * $signed({{WIDTH{md.b[WIDTH-1]}}, md.b});
        prod_u   = {{WIDTH{1'b0}}, md.a} * {{WIDTH{1'b0}}, md.b};
        div_zero = (md.b == '0);
        div_ovf  = (md.a == {1'b1, {(WIDTH-1){1'b0}}}) && (md.b == '1);
        div_b    = (div_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : md.b;
        q_s_raw  = $signed(md.a) / $signed(div_b);
        r_s_raw  = $signed(md.a) % $signed(div_b);
        q_s      = div_ovf ? md.a : q_s_raw;
        r_s      = div_ovf ? '0 : r_s_raw;
        q_u      = md.a / div_b;
        r_u      = md.a % div_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            wr_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            wr_q     <= wr_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        wr_d     = wr_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (md.start) begin
                    case (md.op)
                        3'b000: begin
                            state_d  = S_RUN;
                            cnt_d    = CW'(MULT_CYCLES);
                            res_hi_d = prod_s[2*WIDTH-1:WIDTH];
                            res_lo_d = prod_s[WIDTH-1:0];
                            wr_d     = 1'b1;
                        end
                        3'b001: begin
                            state_d  = S_RUN;
                            cnt_d    = CW'(MULT_CYCLES);
                            res_hi_d = prod_u[2*WIDTH-1:WIDTH];
                            res_lo_d = prod_u[WIDTH-1:0];
                            wr_d     = 1'b1;
                        end
                        3'b010: begin
                            state_d  = S_RUN;
                            cnt_d    = CW'(DIV_CYCLES);
                            res_hi_d = r_s;
                            res_lo_d = q_s;
                            wr_d     = !div_zero;
                        end
                        3'b011: begin
                            state_d  = S_RUN;
                            cnt_d    = CW'(DIV_CYCLES);
                            res_hi_d = r_u;
                            res_lo_d = q_u;
                            wr_d     = !div_zero;
                        end
                        3'b100:  hi_d = md.a;
                        3'b101:  lo_d = md.a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (wr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        md.busy      = (state_q == S_RUN);
        md.done      = done_q;
        md.hi_out    = hi_q;
        md.lo_out    = lo_q;
        md.dbg_state = state_q;
    end
endmodule
